// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control unit: sequences fetch/decode/execute/writeback
// per opcode and counts retired instructions.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction, PC+4; waits on mem_ready
// DECODE    | latch opcode, precompute branch target
// MEM_ADDR  | compute lw/sw effective address
// MEM_READ  | data read; waits on mem_ready
// MEM_WB    | write loaded word to rt
// MEM_WRITE | data write; waits on mem_ready
// R_EXEC    | R-type ALU operation
// R_WB      | write ALU result to rd
// BRANCH    | compare, conditionally load branch target
// JUMP      | load jump target
// I_EXEC    | immediate ALU operation
// I_WB      | write ALU result to rt
// TRAP      | illegal opcode; held until reset
module multicycle_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ALU_OP,
    output logic [3:0]  ALU_I_OP,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        i_or_d,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        instr_done,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  op_q;
    logic [15:0] instr_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            op_q          <= '0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= opcode;
            if (instr_done)
                instr_count_q <= instr_count_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            // op_q is being written this cycle, so decode from the live opcode
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                           state_d = S_R_EXEC;
                    OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_J:                               state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_I_EXEC;
                    default:                            state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    always_comb begin
        ALU_OP     = 2'b00;
        ALU_I_OP   = 4'b0000;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                ALU_OP    = 2'b10;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                ALU_OP     = 2'b01;
                pc_source  = 2'b01;
                pc_write   = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ALU_OP    = 2'b11;
                case (op_q)
                    OP_ADDI: ALU_I_OP = 4'b0010;
                    OP_ORI:  ALU_I_OP = 4'b0001;
                    OP_SLTI: ALU_I_OP = 4'b0100;
                    default: ALU_I_OP = 4'b0000;
                endcase
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
        // Reset overrides everything with quiet FETCH controls
        if (rst) begin
            ALU_OP     = 2'b00;
            ALU_I_OP   = 4'b0000;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            i_or_d     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_source  = 2'b00;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule
